// File: rtl/frame_ctrl_if.sv
// Bundle of call/return requests, operand-stack commands and status for frame_ctrl.
// The controller sits on the slave side; whatever issues calls sits on the master side.
interface frame_ctrl_if #(
  parameter int ST_WIDTH      = 32,
  parameter int ST_LOG2_DEPTH = 6,
  parameter int PC_WIDTH      = 16
);
  logic                     call_req;
  logic [PC_WIDTH-1:0]      call_ret_pc;
  logic [3:0]               call_param_num;
  logic [7:0]               call_local_num;
  logic                     call_result_num;
  logic                     ret_req;
  logic [ST_LOG2_DEPTH:0]   os_top_pointer;
  logic [ST_WIDTH-1:0]      os_pop_window_A;
  logic [3:0]               os_pop_num;
  logic                     os_push_num;
  logic [ST_WIDTH-1:0]      os_push_data;
  logic                     os_call;
  logic [7:0]               os_alloc_size;
  logic                     os_local_set;
  logic [ST_LOG2_DEPTH:0]   os_l_addr;
  logic [ST_WIDTH-1:0]      os_local_set_data;
  logic [ST_LOG2_DEPTH:0]   frame_base;
  logic                     busy;
  logic                     done;
  logic                     ret_valid;
  logic [PC_WIDTH-1:0]      ret_pc;
  logic                     error;
  logic [1:0]               err_cause;

  modport slave (
    input  call_req, call_ret_pc, call_param_num, call_local_num, call_result_num,
    input  ret_req, os_top_pointer, os_pop_window_A,
    output os_pop_num, os_push_num, os_push_data, os_call, os_alloc_size,
    output os_local_set, os_l_addr, os_local_set_data, frame_base,
    output busy, done, ret_valid, ret_pc, error, err_cause
  );

  modport master (
    output call_req, call_ret_pc, call_param_num, call_local_num, call_result_num,
    output ret_req, os_top_pointer, os_pop_window_A,
    input  os_pop_num, os_push_num, os_push_data, os_call, os_alloc_size,
    input  os_local_set, os_l_addr, os_local_set_data, frame_base,
    input  busy, done, ret_valid, ret_pc, error, err_cause
  );
endinterface

// File: rtl/frame_ctrl.sv
// Call/return frame controller: keeps a stack of frame records and sequences
// operand-stack allocate, zero-fill and pop/push commands for calls and returns.
module frame_ctrl #(
  parameter int ST_WIDTH      = 32,
  parameter int ST_LOG2_DEPTH = 6,
  parameter int CS_DEPTH      = 16,
  parameter int PC_WIDTH      = 16
) (
  input logic         clk,
  input logic         rst_n,
  frame_ctrl_if.slave bus
);

  localparam int SP_W  = ST_LOG2_DEPTH + 1;
  localparam int CS_AW = $clog2(CS_DEPTH);
  localparam int CW    = SP_W + 10;
  localparam int REC_W = PC_WIDTH + SP_W;

  typedef enum logic [1:0] {IDLE, CALL_ALLOC, ZERO, RET_POP} state_t;

  state_t state_reg, state_next;

  logic [CS_AW:0]          cs_count_reg;
  logic [SP_W-1:0]         frame_base_reg;
  logic [PC_WIDTH-1:0]     cap_pc_reg;
  logic [3:0]              cap_param_reg;
  logic [7:0]              cap_local_reg;
  logic                    cap_res_reg;
  logic [SP_W-1:0]         cap_top_reg;
  logic [7:0]              zero_idx_reg;
  logic [SP_W-1:0]         rem_reg;
  logic [ST_WIDTH-1:0]     r_reg;
  logic                    ret_res_reg;
  logic [PC_WIDTH-1:0]     ret_pc_reg;
  logic                    done_reg;
  logic                    ret_valid_reg;
  logic                    error_reg;
  logic [1:0]              err_cause_reg;

  // Record RAM holds {return PC, caller frame base}; result flags live in flops
  // because the return range check needs the top flag combinationally in IDLE.
  logic [REC_W-1:0]        cs_mem [CS_DEPTH];
  logic [REC_W-1:0]        rec_rd_reg;
  logic [CS_DEPTH-1:0]     cs_res_reg;
  logic [CS_DEPTH-1:0]     res_we;

  logic [CS_AW-1:0]        top_idx;
  logic [CS_AW-1:0]        wr_idx;
  logic                    cs_full;
  logic                    cs_empty;
  logic [CW-1:0]           call_need;
  logic                    call_range_err;
  logic                    call_ok;
  logic [SP_W:0]           ret_need;
  logic                    ret_range_err;
  logic                    ret_ok;
  logic                    ret_accept;
  logic                    rec_we;
  logic                    zero_last;
  logic                    ret_last;
  logic [3:0]              pop_amt;

  assign top_idx   = CS_AW'(cs_count_reg - 1'b1);
  assign wr_idx    = cs_count_reg[CS_AW-1:0];
  assign cs_full   = (cs_count_reg == (CS_AW+1)'(CS_DEPTH));
  assign cs_empty  = (cs_count_reg == '0);

  assign call_need      = CW'(bus.os_top_pointer) + CW'(bus.call_local_num);
  assign call_range_err = ((SP_W+4)'(bus.call_param_num) > (SP_W+4)'(bus.os_top_pointer)) ||
                          (call_need > (CW'(1) << ST_LOG2_DEPTH));
  assign call_ok        = !cs_full && !call_range_err;

  assign ret_need      = (SP_W+1)'(frame_base_reg) + (SP_W+1)'(cs_res_reg[top_idx]);
  assign ret_range_err = ((SP_W+1)'(bus.os_top_pointer) < ret_need);
  assign ret_ok        = !cs_empty && !ret_range_err;
  // A simultaneous call request always wins over a return request.
  assign ret_accept    = (state_reg == IDLE) && !bus.call_req && bus.ret_req && ret_ok;
  assign rec_we        = (state_reg == CALL_ALLOC);

  assign zero_last = (zero_idx_reg == cap_local_reg - 8'd1);
  assign ret_last  = (rem_reg <= SP_W'(15));
  assign pop_amt   = ret_last ? 4'(rem_reg) : 4'd15;

  // State register
  always_ff @(posedge clk) begin
    if (rst_n) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (bus.call_req) begin
          if (call_ok) state_next = CALL_ALLOC;
        end else if (bus.ret_req && ret_ok) begin
          state_next = RET_POP;
        end
      end
      CALL_ALLOC: state_next = (cap_local_reg != 8'd0) ? ZERO : IDLE;
      ZERO:       if (zero_last) state_next = IDLE;
      RET_POP:    if (ret_last) state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  // Operand-stack commands are pure functions of the current state
  always_comb begin
    bus.busy              = (state_reg != IDLE);
    bus.os_call           = 1'b0;
    bus.os_alloc_size     = 8'd0;
    bus.os_local_set      = 1'b0;
    bus.os_l_addr         = '0;
    bus.os_local_set_data = '0;
    bus.os_pop_num        = 4'd0;
    bus.os_push_num       = 1'b0;
    bus.os_push_data      = '0;
    case (state_reg)
      CALL_ALLOC: begin
        bus.os_call       = 1'b1;
        bus.os_alloc_size = cap_local_reg;
      end
      ZERO: begin
        bus.os_local_set = 1'b1;
        bus.os_l_addr    = cap_top_reg + SP_W'(zero_idx_reg);
      end
      RET_POP: begin
        bus.os_pop_num = pop_amt;
        if (ret_last && ret_res_reg) begin
          bus.os_push_num  = 1'b1;
          bus.os_push_data = r_reg;
        end
      end
      default: ;
    endcase
  end

  assign bus.frame_base = frame_base_reg;
  assign bus.done       = done_reg;
  assign bus.ret_valid  = ret_valid_reg;
  assign bus.ret_pc     = ret_pc_reg;
  assign bus.error      = error_reg;
  assign bus.err_cause  = err_cause_reg;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      cs_count_reg   <= '0;
      frame_base_reg <= '0;
      cap_pc_reg     <= '0;
      cap_param_reg  <= '0;
      cap_local_reg  <= '0;
      cap_res_reg    <= 1'b0;
      cap_top_reg    <= '0;
      zero_idx_reg   <= '0;
      rem_reg        <= '0;
      r_reg          <= '0;
      ret_res_reg    <= 1'b0;
      ret_pc_reg     <= '0;
      done_reg       <= 1'b0;
      ret_valid_reg  <= 1'b0;
      error_reg      <= 1'b0;
      err_cause_reg  <= 2'd0;
    end else begin
      done_reg      <= 1'b0;
      ret_valid_reg <= 1'b0;
      error_reg     <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.call_req) begin
            if (cs_full) begin
              error_reg     <= 1'b1;
              err_cause_reg <= 2'd1;
            end else if (call_range_err) begin
              error_reg     <= 1'b1;
              err_cause_reg <= 2'd3;
            end else begin
              cap_pc_reg    <= bus.call_ret_pc;
              cap_param_reg <= bus.call_param_num;
              cap_local_reg <= bus.call_local_num;
              cap_res_reg   <= bus.call_result_num;
              cap_top_reg   <= bus.os_top_pointer;
              zero_idx_reg  <= 8'd0;
            end
          end else if (bus.ret_req) begin
            if (cs_empty) begin
              error_reg     <= 1'b1;
              err_cause_reg <= 2'd2;
            end else if (ret_range_err) begin
              error_reg     <= 1'b1;
              err_cause_reg <= 2'd3;
            end else begin
              if (cs_res_reg[top_idx]) r_reg <= bus.os_pop_window_A;
              ret_res_reg <= cs_res_reg[top_idx];
              rem_reg     <= bus.os_top_pointer - frame_base_reg;
            end
          end
        end
        CALL_ALLOC: begin
          cs_count_reg   <= cs_count_reg + 1'b1;
          frame_base_reg <= cap_top_reg - SP_W'(cap_param_reg);
          if (cap_local_reg == 8'd0) done_reg <= 1'b1;
        end
        ZERO: begin
          zero_idx_reg <= zero_idx_reg + 8'd1;
          if (zero_last) done_reg <= 1'b1;
        end
        RET_POP: begin
          rem_reg <= rem_reg - SP_W'(pop_amt);
          if (ret_last) begin
            frame_base_reg <= rec_rd_reg[SP_W-1:0];
            ret_pc_reg     <= rec_rd_reg[REC_W-1:SP_W];
            cs_count_reg   <= cs_count_reg - 1'b1;
            done_reg       <= 1'b1;
            ret_valid_reg  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rec_we) cs_mem[wr_idx] <= {cap_pc_reg, frame_base_reg};
    if (ret_accept) rec_rd_reg <= cs_mem[top_idx];
  end

  genvar gi;
  generate
    for (gi = 0; gi < CS_DEPTH; gi++) begin : g_res_we
      assign res_we[gi] = rec_we && (wr_idx == CS_AW'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst_n) begin
      cs_res_reg <= '0;
    end else begin
      for (int i = 0; i < CS_DEPTH; i++) begin
        if (res_we[i]) cs_res_reg[i] <= cap_res_reg;
      end
    end
  end

endmodule

// File: tb/tb_frame_ctrl.sv
// Directed bench for frame_ctrl: each request queues its expected operand-stack
// commands and completion events with cycle stamps; a monitor pops and compares them.
module tb_frame_ctrl;

  localparam int K_ALLOC = 1;
  localparam int K_ZERO  = 2;
  localparam int K_POP   = 3;
  localparam int K_DONE  = 4;
  localparam int K_ERR   = 5;

  typedef struct packed {
    logic [31:0] cyc;
    logic [2:0]  kind;
    logic [63:0] payload;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_assert = 0;
  int   n_fail = 0;
  ev_t  sb[$];

  int   m_count = 0;
  int   m_fb = 0;
  int   m_ret_pc = 0;
  int   m_pc[$];
  int   m_ofb[$];
  int   m_res[$];

  frame_ctrl_if #(.ST_WIDTH(32), .ST_LOG2_DEPTH(6), .PC_WIDTH(16)) bus ();

  frame_ctrl #(.ST_WIDTH(32), .ST_LOG2_DEPTH(6), .CS_DEPTH(16), .PC_WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kname(input logic [2:0] k);
    case (k)
      3'd1: return "alloc";
      3'd2: return "zero_write";
      3'd3: return "pop_push";
      3'd4: return "done";
      3'd5: return "error";
      default: return "none";
    endcase
  endfunction

  function automatic void push_ev(input int c, input int k, input logic [63:0] p);
    ev_t e;
    e.cyc = 32'(c);
    e.kind = 3'(k);
    e.payload = p;
    sb.push_back(e);
  endfunction

  function automatic void exp_call(input int c, input int pc, input int param,
                                   input int lcl, input int res, input int top);
    if (m_count == 16) begin
      push_ev(c + 1, K_ERR, 64'd1);
    end else if (param > top || top + lcl > 64) begin
      push_ev(c + 1, K_ERR, 64'd3);
    end else begin
      push_ev(c + 1, K_ALLOC, 64'(lcl));
      for (int i = 0; i < lcl; i++) push_ev(c + 2 + i, K_ZERO, 64'({32'd0, 7'(top + i)}));
      m_pc.push_back(pc);
      m_ofb.push_back(m_fb);
      m_res.push_back(res);
      m_fb = top - param;
      m_count++;
      push_ev(c + 2 + lcl, K_DONE, 64'({1'b0, 16'(m_ret_pc), 7'(m_fb)}));
    end
  endfunction

  function automatic void exp_ret(input int c, input int top, input logic [31:0] a);
    int rem, pop, k, res;
    if (m_count == 0) begin
      push_ev(c + 1, K_ERR, 64'd2);
    end else if (top < m_fb + m_res[m_res.size() - 1]) begin
      push_ev(c + 1, K_ERR, 64'd3);
    end else begin
      res = m_res[m_res.size() - 1];
      rem = top - m_fb;
      k = 0;
      while (1) begin
        k++;
        if (rem <= 15) begin
          if (rem != 0 || res != 0)
            push_ev(c + k, K_POP, 64'({(res != 0) ? a : 32'd0, 1'(res), 4'(rem)}));
          break;
        end
        push_ev(c + k, K_POP, 64'({32'd0, 1'b0, 4'd15}));
        rem -= 15;
      end
      m_ret_pc = m_pc.pop_back();
      m_fb = m_ofb.pop_back();
      void'(m_res.pop_back());
      m_count--;
      push_ev(c + k + 1, K_DONE, 64'({1'b1, 16'(m_ret_pc), 7'(m_fb)}));
    end
  endfunction

  // Monitor: one observed event per cycle at most, compared against the scoreboard head
  always @(negedge clk) begin
    ev_t  obs;
    ev_t  expv;
    logic have;
    if (rst_n === 1'b0) begin
      have = 1'b1;
      obs = '0;
      obs.cyc = 32'(cyc);
      if (bus.os_call === 1'b1) begin
        obs.kind = 3'(K_ALLOC);
        obs.payload = 64'(bus.os_alloc_size);
      end else if (bus.os_local_set === 1'b1) begin
        obs.kind = 3'(K_ZERO);
        obs.payload = 64'({bus.os_local_set_data, bus.os_l_addr});
      end else if (bus.os_pop_num !== 4'd0 || bus.os_push_num !== 1'b0) begin
        obs.kind = 3'(K_POP);
        obs.payload = 64'({bus.os_push_num ? bus.os_push_data : 32'd0, bus.os_push_num, bus.os_pop_num});
      end else if (bus.done === 1'b1) begin
        obs.kind = 3'(K_DONE);
        obs.payload = 64'({bus.ret_valid, bus.ret_pc, bus.frame_base});
      end else if (bus.error === 1'b1) begin
        obs.kind = 3'(K_ERR);
        obs.payload = 64'(bus.err_cause);
      end else begin
        have = 1'b0;
      end
      n_assert++;
      assert (!(bus.os_local_set === 1'b1 && bus.os_push_num === 1'b1)) else begin
        n_fail++;
        $error("FAIL set_push_overlap cycle=%0d observed both high required exclusive", cyc);
      end
      n_assert++;
      assert (!(bus.ret_valid === 1'b1 && bus.done !== 1'b1)) else begin
        n_fail++;
        $error("FAIL ret_valid_without_done cycle=%0d observed done=%b required 1", cyc, bus.done);
      end
      if (have) begin
        n_assert++;
        assert (sb.size() != 0) else begin
          n_fail++;
          $error("FAIL unexpected_%s cycle=%0d observed=%0h required none", kname(obs.kind), cyc, obs.payload);
        end
        if (sb.size() != 0) begin
          expv = sb.pop_front();
          n_assert++;
          assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed cycle=%0d kind=%s data=%0h required cycle=%0d kind=%s data=%0h",
                   kname(expv.kind), obs.cyc, kname(obs.kind), obs.payload,
                   expv.cyc, kname(expv.kind), expv.payload);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h required=%0h", tag, obs, expv);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.busy !== 1'b0 && n < 200) begin
      tick();
      n++;
    end
    chk("idle_timeout", 64'(bus.busy), 64'd0);
    tick();
    tick();
  endtask

  task automatic do_req(input logic c_req, input logic r_req, input int pc, input int param,
                        input int lcl, input int res, input int top, input logic [31:0] a);
    int c;
    bus.call_req        = c_req;
    bus.ret_req         = r_req;
    bus.call_ret_pc     = 16'(pc);
    bus.call_param_num  = 4'(param);
    bus.call_local_num  = 8'(lcl);
    bus.call_result_num = 1'(res);
    bus.os_top_pointer  = 7'(top);
    bus.os_pop_window_A = a;
    c = cyc;
    if (c_req) exp_call(c, pc, param, lcl, res, top);
    else if (r_req) exp_ret(c, top, a);
    tick();
    bus.call_req = 1'b0;
    bus.ret_req  = 1'b0;
    wait_idle();
  endtask

  initial begin
    int c;
    rst_n = 1'b1;
    bus.call_req = 1'b0;
    bus.ret_req = 1'b0;
    bus.call_ret_pc = '0;
    bus.call_param_num = '0;
    bus.call_local_num = '0;
    bus.call_result_num = 1'b0;
    bus.os_top_pointer = '0;
    bus.os_pop_window_A = '0;
    tick();
    tick();
    rst_n = 1'b0;

    chk("reset_busy", 64'(bus.busy), 64'd0);
    chk("reset_frame_base", 64'(bus.frame_base), 64'd0);
    chk("reset_ret_pc", 64'(bus.ret_pc), 64'd0);
    chk("reset_err_cause", 64'(bus.err_cause), 64'd0);
    chk("reset_strobes", 64'({bus.os_call, bus.os_local_set, bus.os_push_num, bus.os_pop_num,
                              bus.done, bus.ret_valid, bus.error}), 64'd0);

    do_req(1'b0, 1'b1, 0, 0, 0, 0, 0, 32'h0);            // return with no records
    chk("err_cause_underflow", 64'(bus.err_cause), 64'd2);

    do_req(1'b1, 1'b0, 'h40, 2, 3, 1, 5, 32'h0);         // basic call with locals
    do_req(1'b0, 1'b1, 0, 0, 0, 0, 10, 32'hAB);          // return carrying 0xAB
    chk("err_cause_held", 64'(bus.err_cause), 64'd2);
    chk("ret_pc_held", 64'(bus.ret_pc), 64'h40);
    chk("frame_base_restored", 64'(bus.frame_base), 64'd0);

    do_req(1'b1, 1'b0, 'h1111, 0, 0, 1, 20, 32'h0);      // frame at 20, no locals
    do_req(1'b0, 1'b1, 0, 0, 0, 0, 60, 32'h1234);        // remaining 40: 15,15,10

    do_req(1'b1, 1'b1, 'h77, 1, 2, 0, 3, 32'h0);         // call wins over return
    do_req(1'b0, 1'b1, 0, 0, 0, 0, 5, 32'hDEAD);         // pop 3, no result

    do_req(1'b1, 1'b0, 'h3333, 0, 10, 0, 60, 32'h0);     // 70 > 64
    do_req(1'b1, 1'b0, 'h3334, 2, 0, 0, 1, 32'h0);       // params exceed top
    do_req(1'b1, 1'b0, 'h4444, 0, 4, 0, 60, 32'h0);      // exactly fills the stack
    do_req(1'b0, 1'b1, 0, 0, 0, 0, 64, 32'h0);

    do_req(1'b1, 1'b0, 'h2222, 4, 0, 1, 4, 32'h0);
    do_req(1'b0, 1'b1, 0, 0, 0, 0, 0, 32'h55);           // result slot missing
    do_req(1'b0, 1'b1, 0, 0, 0, 0, 1, 32'h55);
    do_req(1'b1, 1'b0, 'h5555, 0, 0, 0, 7, 32'h0);
    do_req(1'b0, 1'b1, 0, 0, 0, 0, 7, 32'h0);            // empty frame
    chk("err_cause_range_held", 64'(bus.err_cause), 64'd3);

    // Reset lands mid zero-fill: only the first two writes are expected
    bus.call_req = 1'b1;
    bus.ret_req = 1'b0;
    bus.call_ret_pc = 16'h99;
    bus.call_param_num = 4'd0;
    bus.call_local_num = 8'd10;
    bus.call_result_num = 1'b0;
    bus.os_top_pointer = 7'd10;
    c = cyc;
    push_ev(c + 1, K_ALLOC, 64'd10);
    push_ev(c + 2, K_ZERO, 64'd10);
    push_ev(c + 3, K_ZERO, 64'd11);
    tick();
    bus.call_req = 1'b0;
    tick();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    rst_n = 1'b0;
    tick();
    tick();
    tick();
    m_count = 0;
    m_fb = 0;
    m_ret_pc = 0;
    m_pc.delete();
    m_ofb.delete();
    m_res.delete();
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_local_set", 64'(bus.os_local_set), 64'd0);
    chk("abort_frame_base", 64'(bus.frame_base), 64'd0);
    chk("abort_ret_pc", 64'(bus.ret_pc), 64'd0);
    chk("abort_err_cause", 64'(bus.err_cause), 64'd0);
    chk("abort_pending_events", 64'(sb.size()), 64'd0);
    do_req(1'b0, 1'b1, 0, 0, 0, 0, 10, 32'h0);           // records cleared by reset

    for (int i = 0; i < 16; i++) do_req(1'b1, 1'b0, 'h100 + i, 0, 0, 0, i, 32'h0);
    do_req(1'b1, 1'b0, 'h200, 0, 0, 0, 16, 32'h0);       // 17th nested call
    chk("err_cause_overflow", 64'(bus.err_cause), 64'd1);
    do_req(1'b0, 1'b1, 0, 0, 0, 0, 15, 32'h0);

    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/frame_ctrl.md
FRAME_CTRL -- requirements
Module: frame_ctrl

Interface
REQ-001 Parameters SHALL be:
  ST_WIDTH, 32, operand word width;
  ST_LOG2_DEPTH, 6, log2 of operand stack depth; stack pointers are ST_LOG2_DEPTH+1 bits;
  CS_DEPTH, 16, number of frame records;
  PC_WIDTH, 16, return-PC width.
REQ-002 Ports SHALL be (name  direction  width  meaning):
  clk  in  1  the single clock; all state changes on rising edge;
  rst_n  in  1  reset, synchronous and active-high (rst_n=1 resets);
  call_req  in  1  call request;
  call_ret_pc  in  PC_WIDTH  PC to resume after return;
  call_param_num  in  4  parameters already on operand stack;
  call_local_num  in  8  extra locals to allocate and zero;
  call_result_num  in  1  callee result count (0 or 1);
  ret_req  in  1  return request;
  os_top_pointer  in  ST_LOG2_DEPTH+1  operand stack top (count of valid entries);
  os_pop_window_A  in  ST_WIDTH  current top entry;
  os_pop_num  out  4  entries to pop this cycle;
  os_push_num  out  1  entries to push this cycle;
  os_push_data  out  ST_WIDTH  push data;
  os_call  out  1  allocate os_alloc_size entries this cycle;
  os_alloc_size  out  8  allocation size;
  os_local_set  out  1  write os_local_set_data at os_l_addr;
  os_l_addr  out  ST_LOG2_DEPTH+1  local write address;
  os_local_set_data  out  ST_WIDTH  local write data;
  frame_base  out  ST_LOG2_DEPTH+1  absolute address of local 0 of current frame;
  busy  out  1  high whenever state is not IDLE;
  done  out  1  one-cycle pulse: call or return complete;
  ret_valid  out  1  one-cycle pulse with done on return completion;
  ret_pc  out  PC_WIDTH  restored PC, valid while ret_valid;
  error  out  1  one-cycle pulse: request rejected;
  err_cause  out  2  1=frame-stack overflow, 2=frame-stack underflow, 3=operand range; held until next error.

Function
REQ-003 The FSM SHALL have states IDLE, CALL_ALLOC, ZERO, RET_POP; requests SHALL be sampled only in IDLE and ignored otherwise.
REQ-004 call_req and ret_req both high in IDLE: the call SHALL be executed and the return dropped.
REQ-005 Call accept in IDLE SHALL check, in priority order: record count == CS_DEPTH -> cause 1; call_param_num > os_top_pointer, or os_top_pointer + call_local_num > 2^ST_LOG2_DEPTH -> cause 3. On error: pulse error, stay in IDLE, change nothing else.
REQ-006 A valid call SHALL capture all call inputs and the old top T, then go to CALL_ALLOC.
REQ-007 CALL_ALLOC SHALL last one cycle with os_call=1, os_alloc_size=captured local_num, os_pop_num=0, os_push_num=0. The block SHALL push record {ret_pc, old frame_base, result_num} and set frame_base = T - param_num. Next state: ZERO if local_num>0, else IDLE with done pulse.
REQ-008 ZERO SHALL write 0 to address T+i, i=0..local_num-1, one write per cycle via os_local_set. After the last write it SHALL return to IDLE and pulse done in the following cycle.
REQ-009 Return accept in IDLE with zero records SHALL give cause 2. With os_top_pointer < frame_base + result_num it SHALL give cause 3. Otherwise it SHALL capture R = os_pop_window_A when result_num=1, set remaining = os_top_pointer - frame_base, and enter RET_POP.
REQ-010 RET_POP each cycle SHALL drive os_pop_num = min(15, remaining) and decrement remaining by that amount. On the final cycle (remaining <= 15) it SHALL also drive os_push_num = result_num with os_push_data = R, restore frame_base from the record, pop the record, and drive ret_pc.
REQ-011 The cycle after the final RET_POP cycle SHALL be IDLE with done=1 and ret_valid=1; ret_pc SHALL hold until the next return.
REQ-012 os_local_set and os_push_num SHALL never be asserted in the same cycle; os_call SHALL be asserted only in CALL_ALLOC.
REQ-013 Call latency SHALL be 2+local_num cycles from accept to done. Return latency SHALL be 1+ceil(max(remaining,1)/15) cycles.

Reset
REQ-014 On rst_n=1 at a clock edge: state=IDLE, record count=0, frame_base=0, R=0, ret_pc=0, err_cause=0. All strobes and os_* controls SHALL be 0. Reset mid-call or mid-return SHALL abort the operation with no further operand-stack commands.

Verification
REQ-015 Top=5, call(param=2, local=3, result=1, pc=0x40): os_call with size 3 for 1 cycle; zeros written to 5,6,7; frame_base=3; done 5 cycles after accept.
REQ-016 Then push to top=10 with top entry 0xAB, ret: pops 7 with push of 0xAB; top=4; frame_base=0; ret_pc=0x40; ret_valid pulsed.
REQ-017 Return from a frame with remaining=40: pops of 15, 15, 10, final cycle pushes result.
REQ-018 Ret with no records -> error, err_cause=2; 17th nested call -> err_cause=1; top=60, local=10 -> err_cause=3, no os_call.
REQ-019 call_req and ret_req together -> call executes; reset asserted during ZERO -> IDLE, busy=0, no further os_local_set.
